ctr_stream_checker: RTL and testbench

Receive-side checker for the free-running counter pattern that a fabric test design drives onto the board I/O. It samples the counter word and marker field from the pins and verifies that the counter advances by exactly one per clock, wrapping modulo 2^CTR_W. It locks onto the stream and counts mismatches, so one board or fabric instance can verify another's output over the pins.

---
 rtl/ctr_stream_checker.sv | 137 +++++++++++++
 tb/tb_ctr_stream_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ctr_stream_checker.sv
// Receive-side checker for a free-running counter stream: locks after LOCK_COUNT good increments, then counts mismatches.
// Optional macro CTR_CHECK_STICKY_EN: an error while locked parks the FSM in FAIL until clr or reset.
module ctr_stream_checker #(
  parameter int unsigned CTR_W      = 24,
  parameter logic [6:0]  MARKER     = 7'h23,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CTR_W-1:0] rx_ctr,
  input  logic [6:0]       rx_marker,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAIL   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CTR_W-1:0]   s_ctr;
  logic [CTR_W-1:0]   prev_ctr;
  logic [6:0]         s_marker;
  logic               s_vld;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_nx;
  logic               err_nx;
  logic               mk_ok;
  logic               good;

  // Pin capture stage; prev_ctr trails s_ctr once the first sample is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ctr    <= '0;
      s_marker <= '0;
      s_vld    <= 1'b0;
      prev_ctr <= '0;
    end else begin
      s_ctr    <= rx_ctr;
      s_marker <= rx_marker;
      s_vld    <= 1'b1;
      if (s_vld) begin
        prev_ctr <= s_ctr;
      end
    end
  end

  assign mk_ok = (s_marker == MARKER);
  assign good  = s_vld && mk_ok && (s_ctr == CTR_W'(prev_ctr + CTR_W'(1)));

  always_comb begin
    state_nx = state;
    run_nx   = run;
    err_nx   = 1'b0;
    unique case (state)
      ACQ: begin
        if (s_vld && mk_ok) begin
          state_nx = TRACK;
          run_nx   = '0;
        end
      end
      TRACK: begin
        if (good) begin
          run_nx = run + RUN_W'(1);
          if (run == RUN_W'(LOCK_COUNT - 1)) begin
            state_nx = LOCKED;
          end
        end else if (!mk_ok) begin
          state_nx = ACQ;
        end else begin
          run_nx = '0;
        end
      end
      LOCKED: begin
        if (!good) begin
          err_nx = 1'b1;
          run_nx = '0;
`ifdef CTR_CHECK_STICKY_EN
          state_nx = FAIL;
`else
          state_nx = TRACK;
`endif
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = ACQ;
        run_nx   = '0;
      end
    endcase
    // clr overrides everything, including an error detected in the same cycle.
    if (clr) begin
      state_nx = ACQ;
      run_nx   = '0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACQ;
      run       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      run       <= run_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (err_nx && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ctr_stream_checker.sv
// Directed table-driven bench for ctr_stream_checker (ERR_W=4), plus hand sequences for saturation, clr and async reset.
module tb_ctr_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [23:0] rx_ctr;
  logic [6:0]  rx_marker;
  logic        locked;
  logic        err_pulse;
  logic [3:0]  err_count;
  logic [1:0]  state_dbg;

  int n_pass;
  int n_total;
  logic [23:0] j;

  typedef struct {
    logic [23:0] ctr;
    logic [6:0]  mk;
    logic        clr;
    logic        l;
    logic        p;
    logic [3:0]  c;
    logic [1:0]  s;
  } vec_t;

  vec_t tbl [48];

  ctr_stream_checker #(
    .CTR_W(24),
    .MARKER(7'h23),
    .LOCK_COUNT(4),
    .ERR_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .rx_ctr(rx_ctr),
    .rx_marker(rx_marker),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic l, input logic p, input logic [3:0] c,
                           input logic [1:0] s);
    check({tag, ".locked"}, 32'(locked), 32'(l));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(p));
    check({tag, ".err_count"}, 32'(err_count), 32'(c));
    check({tag, ".state_dbg"}, 32'(state_dbg), 32'(s));
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic drive(input logic [23:0] c, input logic [6:0] m, input logic cl);
    rx_ctr    = c;
    rx_marker = m;
    clr       = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    for (int i = 0; i < 48; i++) begin
      tbl[i] = '{ctr: 24'h0, mk: 7'h23, clr: 1'b0, l: 1'b0, p: 1'b0, c: 4'h0, s: 2'd0};
    end
    // Clean stream from reset: lock after edge 5.
    for (int i = 0; i < 10; i++) begin
      tbl[i].ctr = 24'(i);
      tbl[i].s   = (i == 0) ? 2'd0 : (i < 5) ? 2'd1 : 2'd2;
      tbl[i].l   = (i >= 5);
    end
    // clr, relock below the wrap point, then run across FFFFFF -> 000000.
    for (int i = 10; i < 22; i++) begin
      tbl[i].ctr = 24'hFFFFF8 + 24'(i - 10);
      tbl[i].clr = (i == 10);
      tbl[i].s   = (i == 10) ? 2'd0 : (i < 15) ? 2'd1 : 2'd2;
      tbl[i].l   = (i >= 15);
    end
    // clr, lock, then 0x100 where 0x50 is expected, stream continues from 0x100.
    for (int i = 22; i < 36; i++) begin
      tbl[i].ctr = (i < 29) ? 24'h49 + 24'(i - 22) : 24'h100 + 24'(i - 29);
      tbl[i].clr = (i == 22);
      tbl[i].s   = (i == 22) ? 2'd0 : (i < 27) ? 2'd1 : (i < 30) ? 2'd2 : (i < 34) ? 2'd1 : 2'd2;
      tbl[i].l   = ((i >= 27) && (i < 30)) || (i >= 34);
      tbl[i].c   = (i >= 30) ? 4'd1 : 4'd0;
      tbl[i].p   = (i == 30);
`ifdef CTR_CHECK_STICKY_EN
      if (i >= 30) begin
        tbl[i].s = 2'd3;
        tbl[i].l = 1'b0;
      end
`endif
    end
    // clr, enter TRACK, marker lost for 3 samples, restore and relock.
    for (int i = 36; i < 48; i++) begin
      tbl[i].ctr = 24'h107 + 24'(i - 36);
      tbl[i].mk  = ((i >= 38) && (i <= 40)) ? 7'h00 : 7'h23;
      tbl[i].clr = (i == 36);
      tbl[i].s   = (i == 36) ? 2'd0 : (i <= 38) ? 2'd1 : (i <= 41) ? 2'd0 : (i <= 45) ? 2'd1 : 2'd2;
      tbl[i].l   = (i >= 46);
    end

    rst_n     = 1'b0;
    clr       = 1'b0;
    rx_ctr    = 24'h0;
    rx_marker = 7'h23;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 4'h0, 2'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      drive(tbl[i].ctr, tbl[i].mk, tbl[i].clr);
      check_all($sformatf("v%0d", i), tbl[i].l, tbl[i].p, tbl[i].c, tbl[i].s);
    end

`ifndef CTR_CHECK_STICKY_EN
    // 20 jump errors, each followed by a relock; count saturates at 15.
    for (int k = 0; k < 20; k++) begin
      j = 24'h200000 + 24'(k * 4096);
      drive(j, 7'h23, 1'b0);
      drive(j + 24'd1, 7'h23, 1'b0);
      check($sformatf("sat%0d.err_pulse", k), 32'(err_pulse), 32'd1);
      check($sformatf("sat%0d.locked_low", k), 32'(locked), 32'd0);
      for (int n = 2; n <= 5; n++) drive(j + 24'(n), 7'h23, 1'b0);
      check($sformatf("sat%0d.relocked", k), 32'(locked), 32'd1);
      check($sformatf("sat%0d.err_count", k), 32'(err_count), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
    end
`endif

    // Error detected in the same cycle as clr is discarded.
    drive(24'h300000, 7'h23, 1'b0);
    drive(24'h300001, 7'h23, 1'b1);
    check_all("clr_err", 1'b0, 1'b0, 4'h0, 2'd0);
    for (int n = 2; n <= 6; n++) drive(24'h300000 + 24'(n), 7'h23, 1'b0);
    check_all("relock_after_clr", 1'b1, 1'b0, 4'h0, 2'd2);

`ifndef CTR_CHECK_STICKY_EN
    drive(24'h400000, 7'h23, 1'b0);
    drive(24'h400001, 7'h23, 1'b0);
    check_all("pre_rst_err", 1'b0, 1'b1, 4'h1, 2'd1);
    for (int n = 2; n <= 5; n++) drive(24'h400000 + 24'(n), 7'h23, 1'b0);
    check_all("pre_rst_lock", 1'b1, 1'b0, 4'h1, 2'd2);
`endif

    // Async reset between edges must clear outputs before the next posedge.
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 1'b0, 1'b0, 4'h0, 2'd0);
    @(negedge clk);
    check_all("rst_held", 1'b0, 1'b0, 4'h0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
